// File: rtl/lite_mode_slave.sv
// Single-port register slave with a two-bit mode register that selects the read transform.
// Optional macro LITE_MODE_SLAVE_ERR_EN adds an err pulse for requests made while busy.
module lite_mode_slave #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              trans,
    input  logic              write,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              readyout,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        mode,
    output logic              busy
`ifdef LITE_MODE_SLAVE_ERR_EN
    ,
    output logic              err
`endif
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   scratch_q, scratch_d;
    logic                readyout_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                capture;
    logic                enter_resp;
    logic                cur_write;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic [DATA_W-1:0]   addr_ext;
    logic [DATA_W-1:0]   read_val;
    logic [DATA_W-1:0]   resp_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trans) begin
                    capture = 1'b1;
                    cnt_d   = WaitLoad;
                    state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
                end
            end
            StWait: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign enter_resp = (state_d == StResp);

    // With no wait states the response is formed in the capture cycle, straight from the inputs.
    always_comb begin
        cur_write = (state_q == StIdle) ? write : write_q;
        cur_addr  = (state_q == StIdle) ? waddr : addr_q;
        cur_wdata = (state_q == StIdle) ? wdata : wdata_q;
        addr_ext  = DATA_W'(cur_addr);
        unique case (mode_q)
            2'd0: read_val = addr_ext >> 1;
            2'd1: read_val = (addr_ext << 1) + addr_ext + DATA_W'(1);
            2'd2: read_val = addr_ext ^ scratch_q;
            2'd3: read_val = addr_ext + scratch_q;
            default: read_val = '0;
        endcase
        resp_data = cur_write ? cur_wdata : read_val;
    end

    always_comb begin
        mode_d    = mode_q;
        scratch_d = scratch_q;
        if (enter_resp && cur_write) begin
            if (cur_addr == '0) begin
                mode_d = cur_wdata[1:0];
            end else if (cur_addr == ADDR_W'(1)) begin
                scratch_d = cur_wdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mode_q     <= '0;
            scratch_q  <= '0;
            readyout_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            scratch_q  <= scratch_d;
            readyout_q <= enter_resp;
            if (capture) begin
                write_q <= write;
                addr_q  <= waddr;
                wdata_q <= wdata;
            end
            if (enter_resp) begin
                rdata_q <= resp_data;
            end
        end
    end

    assign readyout = readyout_q;
    assign rdata    = rdata_q;
    assign mode     = mode_q;
    assign busy     = (state_q != StIdle);

`ifdef LITE_MODE_SLAVE_ERR_EN
    logic err_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= trans && (state_q != StIdle);
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_lite_mode_slave.sv
// Bench for lite_mode_slave: four instances (default, zero wait, 15 waits, 4-bit data)
// checked against a behavioural model of the mode/scratch registers.
module tb_lite_mode_slave;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       trans = 1'b0;
    logic       write = 1'b0;
    logic [7:0] waddr = 8'h00;
    logic [7:0] wdata = 8'h00;
    int         sel   = 0;

    int n_checks = 0;
    int n_fails  = 0;
    int mode_m    [4];
    int scratch_m [4];

    logic       t0, t1, t2, t3;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic [7:0] rd0, rd1, rd2;
    logic [3:0] rd3;
    logic [1:0] md0, md1, md2, md3;
    logic       bz0, bz1, bz2, bz3;
    logic       cur_ready, cur_busy;
    logic [7:0] cur_rdata;
    logic [1:0] cur_mode;
`ifdef LITE_MODE_SLAVE_ERR_EN
    logic       er0, er1, er2, er3, cur_err;
`endif

    always #5 clock = ~clock;

    assign t0 = trans && (sel == 0);
    assign t1 = trans && (sel == 1);
    assign t2 = trans && (sel == 2);
    assign t3 = trans && (sel == 3);

    lite_mode_slave u_dut0 (
        .clock (clock), .rst (rst), .trans (t0), .write (write), .waddr (waddr),
        .wdata (wdata), .readyout (rdy0), .rdata (rd0), .mode (md0), .busy (bz0)
`ifdef LITE_MODE_SLAVE_ERR_EN
        , .err (er0)
`endif
    );

    lite_mode_slave #(.WAIT_CYCLES (0)) u_dut1 (
        .clock (clock), .rst (rst), .trans (t1), .write (write), .waddr (waddr),
        .wdata (wdata), .readyout (rdy1), .rdata (rd1), .mode (md1), .busy (bz1)
`ifdef LITE_MODE_SLAVE_ERR_EN
        , .err (er1)
`endif
    );

    lite_mode_slave #(.WAIT_CYCLES (15)) u_dut2 (
        .clock (clock), .rst (rst), .trans (t2), .write (write), .waddr (waddr),
        .wdata (wdata), .readyout (rdy2), .rdata (rd2), .mode (md2), .busy (bz2)
`ifdef LITE_MODE_SLAVE_ERR_EN
        , .err (er2)
`endif
    );

    lite_mode_slave #(.DATA_W (4)) u_dut3 (
        .clock (clock), .rst (rst), .trans (t3), .write (write), .waddr (waddr),
        .wdata (wdata[3:0]), .readyout (rdy3), .rdata (rd3), .mode (md3), .busy (bz3)
`ifdef LITE_MODE_SLAVE_ERR_EN
        , .err (er3)
`endif
    );

    always_comb begin
        cur_ready = rdy0;
        cur_rdata = rd0;
        cur_mode  = md0;
        cur_busy  = bz0;
        case (sel)
            1: begin cur_ready = rdy1; cur_rdata = rd1; cur_mode = md1; cur_busy = bz1; end
            2: begin cur_ready = rdy2; cur_rdata = rd2; cur_mode = md2; cur_busy = bz2; end
            3: begin cur_ready = rdy3; cur_rdata = {4'h0, rd3}; cur_mode = md3; cur_busy = bz3; end
            default: ;
        endcase
    end

`ifdef LITE_MODE_SLAVE_ERR_EN
    always_comb begin
        case (sel)
            1:       cur_err = er1;
            2:       cur_err = er2;
            3:       cur_err = er3;
            default: cur_err = er0;
        endcase
    end
`endif

    function automatic int dw_of(input int k);
        return (k == 3) ? 4 : 8;
    endfunction

    function automatic int wc_of(input int k);
        case (k)
            1:       return 0;
            2:       return 15;
            default: return 1;
        endcase
    endfunction

    function automatic int model_read(input int m, input int s, input int addr, input int dw);
        int mask;
        int a;
        mask = (1 << dw) - 1;
        a    = addr & mask;
        case (m)
            0:       return a >> 1;
            1:       return (3 * a + 1) & mask;
            2:       return (a ^ s) & mask;
            default: return (a + s) & mask;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst   = 1'b1;
        trans = 1'b0;
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mode_m[k]    = 0;
            scratch_m[k] = 0;
        end
    endtask

    // One request on the selected instance; checks latency, one-cycle strobe, data and mode.
    task automatic xfer(input bit wr, input int addr, input int data, output int rd);
        int dw, w, mask, exp_rd, lat;
        dw   = dw_of(sel);
        w    = wc_of(sel);
        mask = (1 << dw) - 1;
        if (wr) begin
            exp_rd = data & mask;
            if (addr == 0) mode_m[sel] = data & 3;
            else if (addr == 1) scratch_m[sel] = data & mask;
        end else begin
            exp_rd = model_read(mode_m[sel], scratch_m[sel], addr, dw);
        end
        @(negedge clock);
        trans = 1'b1;
        write = wr;
        waddr = 8'(addr);
        wdata = 8'(data);
        @(posedge clock);
        #1 trans = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clock);
            if (cur_ready === 1'b1) lat = n;
        end
        check("latency", lat, w + 1);
        rd = int'(cur_rdata);
        if (lat != 0) begin
            check("rdata", cur_rdata, exp_rd);
            check("mode", cur_mode, mode_m[sel]);
            check("busy_in_resp", cur_busy, 1);
        end
        @(negedge clock);
        check("ready_one_cycle", cur_ready, 0);
        check("idle_after_resp", cur_busy, 0);
    endtask

    // trans held high for n_cyc cycles: accepts only in the IDLE cycle after each response.
    task automatic burst(input int k, input int addr, input int n_cyc);
        int w, p, exp_rd;
        sel    = k;
        w      = wc_of(k);
        p      = w + 2;
        exp_rd = model_read(mode_m[k], scratch_m[k], addr, dw_of(k));
        @(negedge clock);
        trans = 1'b1;
        write = 1'b0;
        waddr = 8'(addr);
        @(posedge clock);
        for (int n = 1; n <= n_cyc; n++) begin
            @(negedge clock);
            check("burst_ready", cur_ready, (n % p) == (w + 1));
            check("burst_busy", cur_busy, (n % p) != 0);
            if ((n % p) == (w + 1)) check("burst_rdata", cur_rdata, exp_rd);
`ifdef LITE_MODE_SLAVE_ERR_EN
            check("burst_err", cur_err, ((n - 1) % p) != 0);
`endif
        end
        trans = 1'b0;
        for (int i = 0; i < 40 && cur_busy !== 1'b0; i++) @(negedge clock);
        @(negedge clock);
        check("burst_drained", cur_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd;
        int wr, addr, data;

        do_reset();
        for (int k = 0; k < 4; k++) begin
            sel = k;
            #1;
            check("reset_ready", cur_ready, 0);
            check("reset_rdata", cur_rdata, 0);
            check("reset_mode", cur_mode, 0);
            check("reset_busy", cur_busy, 0);
        end

        sel = 0;
        xfer(0, 8'h0A, 0, rd);
        check("mode0_read_0a", rd, 8'h05);
        xfer(1, 0, 8'h01, rd);
        xfer(0, 8'h55, 0, rd);
        check("mode1_read_55", rd, 8'h00);
        check("mode1_reg", cur_mode, 2'd1);
        xfer(1, 1, 8'hF0, rd);
        xfer(1, 0, 8'h03, rd);
        xfer(0, 8'h20, 0, rd);
        check("mode3_read_20", rd, 8'h10);
        xfer(1, 0, 8'h02, rd);
        xfer(0, 8'h0F, 0, rd);
        check("mode2_read_0f", rd, 8'hFF);
        xfer(1, 8'h07, 8'h5A, rd);
        check("write_other_echo", rd, 8'h5A);

        sel = 1;
        xfer(0, 8'h0A, 0, rd);
        sel = 2;
        xfer(0, 8'h0A, 0, rd);
        burst(1, 8'h33, 6);
        burst(2, 8'h44, 51);

        // Reset while the write to address 0 is still waiting must drop it entirely.
        sel = 0;
        @(negedge clock);
        trans = 1'b1;
        write = 1'b1;
        waddr = 8'h00;
        wdata = 8'h02;
        @(posedge clock);
        #1 trans = 1'b0;
        @(negedge clock);
        rst = 1'b1;
        @(posedge clock);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mode_m[k]    = 0;
            scratch_m[k] = 0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("abort_no_ready", cur_ready, 0);
            check("abort_mode", cur_mode, 0);
        end
        xfer(0, 8'h0A, 0, rd);
        check("after_abort_read", rd, 8'h05);

        sel = 3;
        xfer(0, 8'hA7, 0, rd);
        check("dw4_read_a7", rd, 4'h3);

        for (int k = 0; k < 4; k++) begin
            sel = k;
            for (int i = 0; i < 12; i++) begin
                wr   = int'($urandom_range(0, 1));
                addr = int'($urandom_range(0, 3));
                if (addr > 1) addr = int'($urandom_range(0, 255));
                data = int'($urandom_range(0, 255));
                xfer(wr[0], addr, data, rd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
